// File: rtl/division_unit.sv
// division_unit: RV32M iterative divider (DIV, DIVU, REM, REMU).
// Radix-2 restoring core on operand magnitudes, sign fix-up in a final
// registered stage. One operation in flight; idle_o flags acceptance.
// Optional feature macro: DIV_EARLY_EXIT_EN (divide-by-zero and signed
// overflow skip the iterative phase and finish two enabled edges after accept).

package division_unit_pkg;
   typedef enum logic [1:0] {
      DIV  = 2'b00,
      DIVU = 2'b01,
      REM  = 2'b10,
      REMU = 2'b11
   } div_operation_t;
endpackage

module division_unit
   import division_unit_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  clk_en_i,
   input  logic [DATA_WIDTH-1:0] dividend_i,
   input  logic [DATA_WIDTH-1:0] divisor_i,
   input  logic                  data_valid_i,
   input  div_operation_t        operation_i,
   output logic [DATA_WIDTH-1:0] result_o,
   output logic                  data_valid_o,
   output logic                  idle_o
);

   localparam int unsigned CNT_W = $clog2(DATA_WIDTH);

   typedef enum logic [1:0] {
      S_IDLE,
      S_DIVIDE,
      S_FINALIZE
   } state_t;

   state_t                  state_q, state_d;
   logic [CNT_W-1:0]        cnt_q;
   logic [DATA_WIDTH-1:0]   quo_q;
   logic [DATA_WIDTH-1:0]   rem_q;
   logic [DATA_WIDTH-1:0]   dvsr_q;
   logic                    q_sign_q, r_sign_q, rem_op_q, div_zero_q;

   logic                    is_signed, sign_a, sign_b;
   logic [DATA_WIDTH-1:0]   abs_a, abs_b;
   logic                    div_zero_in, early_exit, last_step;
   logic [DATA_WIDTH:0]     rem_shift;
   logic                    rem_ge;
   logic [DATA_WIDTH-1:0]   rem_next;
   logic [DATA_WIDTH-1:0]   quo_fix, rem_fix;

   // Operand decode at accept: signs only matter for DIV/REM
   always_comb begin
      is_signed   = (operation_i == DIV) || (operation_i == REM);
      sign_a      = is_signed & dividend_i[DATA_WIDTH-1];
      sign_b      = is_signed & divisor_i[DATA_WIDTH-1];
      abs_a       = sign_a ? ('0 - dividend_i) : dividend_i;
      abs_b       = sign_b ? ('0 - divisor_i) : divisor_i;
      div_zero_in = (divisor_i == '0);
   end

`ifdef DIV_EARLY_EXIT_EN
   logic ovf_in;
   // Special cases whose results are known without iterating
   always_comb begin
      ovf_in     = is_signed && (dividend_i == {1'b1, {(DATA_WIDTH-1){1'b0}}})
                   && (divisor_i == '1);
      early_exit = div_zero_in | ovf_in;
   end
`else
   // Every operation traverses the iterative phase
   always_comb begin
      early_exit = 1'b0;
   end
`endif

   // One restoring step: shift in next dividend bit, subtract when it fits.
   // The shifted remainder needs DATA_WIDTH+1 bits, but the stored remainder
   // always fits in DATA_WIDTH bits after the conditional subtract.
   always_comb begin
      last_step = (cnt_q == CNT_W'(DATA_WIDTH - 1));
      rem_shift = {rem_q, quo_q[DATA_WIDTH-1]};
      rem_ge    = (rem_shift >= {1'b0, dvsr_q});
      rem_next  = rem_ge ? (rem_shift[DATA_WIDTH-1:0] - dvsr_q)
                         : rem_shift[DATA_WIDTH-1:0];
      quo_fix   = q_sign_q ? ('0 - quo_q) : quo_q;
      rem_fix   = r_sign_q ? ('0 - rem_q) : rem_q;
   end

   // State register, frozen while the clock enable is low
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
      end else if (clk_en_i) begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:     if (data_valid_i) state_d = early_exit ? S_FINALIZE : S_DIVIDE;
         S_DIVIDE:   if (last_step) state_d = S_FINALIZE;
         S_FINALIZE: state_d = S_IDLE;
         default:    state_d = S_IDLE;
      endcase
   end

   // Datapath: operand capture, iteration, sign fix-up and result register.
   // Divide-by-zero leaves the remainder equal to |dividend| (restoring always
   // subtracts zero), so the normal remainder sign fix-up restores the dividend;
   // only the quotient needs forcing to all ones. Signed overflow falls out of
   // the magnitude path (|a|/1 with equal signs gives -2^(N-1), remainder 0).
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q        <= '0;
         quo_q        <= '0;
         rem_q        <= '0;
         dvsr_q       <= '0;
         q_sign_q     <= 1'b0;
         r_sign_q     <= 1'b0;
         rem_op_q     <= 1'b0;
         div_zero_q   <= 1'b0;
         result_o     <= '0;
         data_valid_o <= 1'b0;
      end else if (clk_en_i) begin
         data_valid_o <= (state_q == S_FINALIZE);
         case (state_q)
            S_IDLE: begin
               if (data_valid_i) begin
                  dvsr_q     <= abs_b;
                  q_sign_q   <= sign_a ^ sign_b;
                  r_sign_q   <= sign_a;
                  rem_op_q   <= (operation_i == REM) || (operation_i == REMU);
                  div_zero_q <= div_zero_in;
                  cnt_q      <= '0;
                  quo_q      <= (early_exit && div_zero_in) ? '1 : abs_a;
                  rem_q      <= (early_exit && div_zero_in) ? abs_a : '0;
               end
            end
            S_DIVIDE: begin
               rem_q <= rem_next;
               quo_q <= {quo_q[DATA_WIDTH-2:0], rem_ge};
               cnt_q <= cnt_q + 1'b1;
            end
            S_FINALIZE: begin
               result_o <= rem_op_q ? rem_fix : (div_zero_q ? '1 : quo_fix);
            end
            default: ;
         endcase
      end
   end

   assign idle_o = (state_q == S_IDLE);

endmodule

// File: tb/tb_division_unit.sv
// tb_division_unit: scoreboard bench for division_unit (DATA_WIDTH=32).
// Expected results are queued at issue and compared on each result pulse.

module tb_division_unit;
   import division_unit_pkg::*;

   localparam int unsigned W = 32;
`ifdef DIV_EARLY_EXIT_EN
   localparam int unsigned SPECIAL_LAT = 2;
`else
   localparam int unsigned SPECIAL_LAT = 34;
`endif
   localparam int unsigned NORMAL_LAT = 34;

   logic           clk_i = 1'b0;
   logic           rst_i;
   logic           clk_en_i;
   logic [W-1:0]   dividend_i, divisor_i;
   logic           data_valid_i;
   div_operation_t operation_i;
   logic [W-1:0]   result_o;
   logic           data_valid_o;
   logic           idle_o;

   division_unit #(.DATA_WIDTH(W)) dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .clk_en_i     (clk_en_i),
      .dividend_i   (dividend_i),
      .divisor_i    (divisor_i),
      .data_valid_i (data_valid_i),
      .operation_i  (operation_i),
      .result_o     (result_o),
      .data_valid_o (data_valid_o),
      .idle_o       (idle_o)
   );

   always #5 clk_i = ~clk_i;

   int unsigned vectors = 0, miscompares = 0;
   int unsigned cyc = 0, pulses = 0, last_pulse_cyc = 0;
   logic        en_at_edge;
   logic [W-1:0] exp_q[$];
   string        tag_q[$];

   task automatic check_equal(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
      end
   endtask

   // Architectural reference, including RISC-V special cases
   function automatic logic [W-1:0] ref_result(input div_operation_t op, input logic [W-1:0] a, input logic [W-1:0] b);
      logic signed [W-1:0] sa, sb;
      logic                ovf;
      sa  = a;
      sb  = b;
      ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      case (op)
         DIV:     return (b == 0) ? 32'hFFFF_FFFF : (ovf ? a : $unsigned(sa / sb));
         DIVU:    return (b == 0) ? 32'hFFFF_FFFF : a / b;
         REM:     return (b == 0) ? a : (ovf ? 32'h0 : $unsigned(sa % sb));
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   // Monitor: one pop per result pulse that follows an enabled edge
   always @(posedge clk_i) begin
      en_at_edge = clk_en_i;
      cyc++;
      #1;
      if (data_valid_o && en_at_edge) begin
         pulses++;
         last_pulse_cyc = cyc;
         if (exp_q.size() == 0) check_equal("unexpected pulse", 32'd1, 32'd0);
         else check_equal({tag_q.pop_front(), " result"}, result_o, exp_q.pop_front());
      end
   end

   task automatic drive(input div_operation_t op, input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
      operation_i  = op;
      dividend_i   = a;
      divisor_i    = b;
      data_valid_i = 1'b1;
      exp_q.push_back(ref_result(op, a, b));
      tag_q.push_back(tag);
   endtask

   // Called at a negedge right after drive(); returns at the negedge of the pulse cycle
   task automatic wait_result(input string tag, input int unsigned lat, input int unsigned stall_at,
                              input int unsigned stall_len, input logic junk);
      int unsigned p0, acc;
      logic        busy_idle;
      p0        = pulses;
      busy_idle = 1'b0;
      @(posedge clk_i);
      #1;
      acc = cyc;
      for (int unsigned i = 0; i < 200; i++) begin
         @(negedge clk_i);
         if (pulses != p0) break;
         if (i == 0) begin
            if (junk) begin
               dividend_i = $urandom;
               divisor_i  = 32'd3;
            end else begin
               data_valid_i = 1'b0;
            end
         end
         if (junk && i == 28) data_valid_i = 1'b0;
         if (stall_len != 0 && i == stall_at) clk_en_i = 1'b0;
         if (stall_len != 0 && i == stall_at + stall_len) clk_en_i = 1'b1;
         if (idle_o !== 1'b0) busy_idle = 1'b1;
      end
      if (pulses == p0) begin
         check_equal({tag, " timeout"}, 32'd0, 32'd1);
         void'(exp_q.pop_back());
         void'(tag_q.pop_back());
         data_valid_i = 1'b0;
         clk_en_i     = 1'b1;
      end else begin
         check_equal({tag, " latency"}, acc <= last_pulse_cyc ? last_pulse_cyc - acc + 1 : 0, lat);
         check_equal({tag, " idle low while busy"}, {31'd0, busy_idle}, 32'd0);
         check_equal({tag, " idle in pulse cycle"}, {31'd0, idle_o}, 32'd1);
      end
   endtask

   task automatic issue(input div_operation_t op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input string tag, input int unsigned lat);
      @(negedge clk_i);
      drive(op, a, b, tag);
      wait_result(tag, lat, 0, 0, 1'b0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int unsigned p_saved;
      logic [W-1:0] a, b;
      rst_i        = 1'b1;
      clk_en_i     = 1'b1;
      data_valid_i = 1'b0;
      dividend_i   = '0;
      divisor_i    = '0;
      operation_i  = DIV;
      repeat (3) @(negedge clk_i);
      check_equal("reset result_o", result_o, 32'd0);
      check_equal("reset data_valid_o", {31'd0, data_valid_o}, 32'd0);
      check_equal("reset idle_o", {31'd0, idle_o}, 32'd1);
      rst_i = 1'b0;

      issue(DIV,  32'd100,        -32'sd7,        "div 100/-7",        NORMAL_LAT);
      issue(REM,  -32'sd100,      32'd7,          "rem -100/7",        NORMAL_LAT);
      issue(REMU, 32'hFFFF_FF9C,  32'd7,          "remu ffffff9c/7",   NORMAL_LAT);
      issue(DIVU, 32'h8000_0000,  32'd0,          "divu by zero",      SPECIAL_LAT);
      issue(REM,  32'h1234_5678,  32'd0,          "rem by zero",       SPECIAL_LAT);
      issue(DIV,  32'h8000_0000,  32'hFFFF_FFFF,  "div overflow",      SPECIAL_LAT);
      issue(REM,  32'h8000_0000,  32'hFFFF_FFFF,  "rem overflow",      SPECIAL_LAT);
      issue(DIV,  -32'sd5,        32'd0,          "div neg by zero",   SPECIAL_LAT);
      issue(REM,  -32'sd5,        32'd0,          "rem neg by zero",   SPECIAL_LAT);
      issue(DIVU, 32'hFFFF_FFFF,  32'd1,          "divu max/1",        NORMAL_LAT);
      issue(DIVU, 32'd0,          32'd5,          "divu 0/5",          NORMAL_LAT);
      issue(DIV,  32'd7,          32'hFFFF_FFFF,  "div 7/-1",          NORMAL_LAT);

      for (int k = 0; k < 8; k++) begin
         a = $urandom;
         b = $urandom;
         if (k % 2 == 1) b = b >> (k * 3);
         if (b == 0) b = 32'd1;
         issue(div_operation_t'(k % 4), a, b, $sformatf("random %0d", k), NORMAL_LAT);
      end

      // Clock enable held low for 5 cycles mid-operation
      @(negedge clk_i);
      drive(DIV, 32'd1000, 32'd3, "div stalled");
      wait_result("div stalled", NORMAL_LAT + 5, 10, 5, 1'b0);

      // Back-to-back: second operation offered in the pulse cycle; a valid during busy is dropped
      @(negedge clk_i);
      drive(DIVU, 32'd12345, 32'd100, "b2b first");
      wait_result("b2b first", NORMAL_LAT, 0, 0, 1'b0);
      drive(DIV, -32'sd77, 32'd5, "b2b second");
      wait_result("b2b second", NORMAL_LAT, 0, 0, 1'b1);
      p_saved = pulses;
      repeat (40) @(negedge clk_i);
      check_equal("no pulse from dropped valid", pulses, p_saved);

      // Reset in cycle 10 of a DIV: operation discarded
      @(negedge clk_i);
      operation_i  = DIV;
      dividend_i   = 32'd100;
      divisor_i    = 32'hFFFF_FFF9;
      data_valid_i = 1'b1;
      @(negedge clk_i);
      data_valid_i = 1'b0;
      repeat (8) @(negedge clk_i);
      p_saved = pulses;
      rst_i = 1'b1;
      #1;
      check_equal("mid-op reset result_o", result_o, 32'd0);
      check_equal("mid-op reset data_valid_o", {31'd0, data_valid_o}, 32'd0);
      check_equal("mid-op reset idle_o", {31'd0, idle_o}, 32'd1);
      repeat (2) @(negedge clk_i);
      rst_i = 1'b0;
      repeat (40) @(negedge clk_i);
      check_equal("no pulse after reset", pulses, p_saved);
      check_equal("idle after reset", {31'd0, idle_o}, 32'd1);
      issue(DIVU, 32'd50, 32'd7, "divu after reset", NORMAL_LAT);

      check_equal("scoreboard drained", exp_q.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
